// File: rtl/alu_exec_unit.sv
// Integer ALU functional unit: takes issued ops from the reservation station, executes them
// in one E stage, and queues results for CDB broadcast under a req/grant handshake.
module alu_exec_unit #(
  parameter int TAG_W = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [2:0]       issue_aluop,
  input  logic             issue_is_cmp,
  input  logic             issue_cmp_uns,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  output logic             busy
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int CNT_W1 = CNT_W + 1;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SLL = 3'b001,
    ALU_SRA = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_op_e;

  logic             e_valid;
  alu_op_e          e_aluop;
  logic             e_is_cmp;
  logic             e_cmp_uns;
  logic [31:0]      e_a;
  logic [31:0]      e_b;
  logic [TAG_W-1:0] e_tag;
  logic [31:0]      e_result;

  logic [TAG_W-1:0] buf_tag  [DEPTH];
  logic [31:0]      buf_data [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             pop;
  logic             accept;
  logic [CNT_W1-1:0] slots_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts the op sitting in E, so E can always push without stalling.
  assign cdb_req     = (count != '0);
  assign pop         = cdb_req & cdb_grant & ~flush;
  assign slots_used  = {1'b0, count} + CNT_W1'(e_valid) - CNT_W1'(pop);
  assign issue_ready = ~flush & (slots_used < CNT_W1'(DEPTH));
  assign accept      = issue_valid & issue_ready;
  assign cdb_tag     = cdb_req ? buf_tag[head]  : '0;
  assign cdb_data    = cdb_req ? buf_data[head] : '0;
  assign busy        = e_valid | cdb_req;

  always_comb begin
    e_result = '0;
    if (e_is_cmp) begin
      e_result = {31'b0, e_cmp_uns ? (e_a < e_b) : ($signed(e_a) < $signed(e_b))};
    end else begin
      case (e_aluop)
        ALU_ADD: e_result = e_a + e_b;
        ALU_SUB: e_result = e_a - e_b;
        ALU_SLL: e_result = e_a << e_b[4:0];
        ALU_SRL: e_result = e_a >> e_b[4:0];
        ALU_SRA: e_result = $unsigned($signed(e_a) >>> e_b[4:0]);
        ALU_XOR: e_result = e_a ^ e_b;
        ALU_OR:  e_result = e_a | e_b;
        ALU_AND: e_result = e_a & e_b;
        default: e_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid   <= 1'b0;
      e_aluop   <= ALU_ADD;
      e_is_cmp  <= 1'b0;
      e_cmp_uns <= 1'b0;
      e_a       <= '0;
      e_b       <= '0;
      e_tag     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else if (flush) begin
      e_valid <= 1'b0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      e_valid <= accept;
      if (accept) begin
        e_aluop   <= alu_op_e'(issue_aluop);
        e_is_cmp  <= issue_is_cmp;
        e_cmp_uns <= issue_cmp_uns;
        e_a       <= issue_a;
        e_b       <= issue_b;
        e_tag     <= issue_tag;
      end
      if (e_valid) tail <= ptr_inc(tail);
      if (pop)     head <= ptr_inc(head);
      count <= count + CNT_W'(e_valid) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only visible while count says they are live.
  always_ff @(posedge clk) begin
    if (e_valid && !flush) begin
      buf_tag[tail]  <= e_tag;
      buf_data[tail] <= e_result;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: ALU results, CDB latency, backpressure,
// back-to-back throughput, flush and asynchronous reset.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_aluop = 3'b0;
  logic        issue_is_cmp = 1'b0;
  logic        issue_cmp_uns = 1'b0;
  logic [31:0] issue_a = '0;
  logic [31:0] issue_b = '0;
  logic [2:0]  issue_tag = '0;
  logic        cdb_req;
  logic        cdb_grant = 1'b0;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  alu_exec_unit #(.TAG_W(3), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_aluop(issue_aluop), .issue_is_cmp(issue_is_cmp), .issue_cmp_uns(issue_cmp_uns),
    .issue_a(issue_a), .issue_b(issue_b), .issue_tag(issue_tag),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic is_cmp,
                               input logic uns, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] tag);
    issue_valid   = valid;
    issue_aluop   = op;
    issue_is_cmp  = is_cmp;
    issue_cmp_uns = uns;
    issue_a       = a;
    issue_b       = b;
    issue_tag     = tag;
  endtask

  // One op through an idle unit with grant held high; checks latency, payload and 1-cycle req.
  task automatic run_op(input string name, input logic [2:0] op, input logic is_cmp,
                        input logic uns, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] tag, input logic [31:0] expected);
    int cycles;
    @(negedge clk);
    cdb_grant = 1'b1;
    applyStimulus(1'b1, op, is_cmp, uns, a, b, tag);
    #1 checkOutput({name, "_ready"}, issue_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 3'b0, 1'b0, 1'b0, '0, '0, '0);
    cycles = 1;
    while (!cdb_req && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, "_latency"}, cycles, 2);
    checkOutput({name, "_data"}, cdb_data, expected);
    checkOutput({name, "_tag"}, cdb_tag, tag);
    @(negedge clk);
    checkOutput({name, "_req_drop"}, cdb_req, 1'b0);
  endtask

  initial begin
    #12;
    checkOutput("rst_req", cdb_req, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_tag", cdb_tag, 3'd0);
    checkOutput("rst_data", cdb_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("add",  3'b000, 1'b0, 1'b0, 32'd5,        32'd7,        3'd3, 32'd12);
    run_op("sra",  3'b010, 1'b0, 1'b0, 32'h80000000, 32'h24,       3'd1, 32'hF8000000);
    run_op("srl",  3'b101, 1'b0, 1'b0, 32'h80000000, 32'h24,       3'd2, 32'h08000000);
    run_op("sub",  3'b011, 1'b0, 1'b0, 32'd0,        32'd1,        3'd4, 32'hFFFFFFFF);
    run_op("sll",  3'b001, 1'b0, 1'b0, 32'd1,        32'h3F,       3'd5, 32'h80000000);
    run_op("xor",  3'b100, 1'b0, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 3'd6, 32'hFF000FF0);
    run_op("or",   3'b110, 1'b0, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 3'd7, 32'hFFF00FFF);
    run_op("and",  3'b111, 1'b0, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 3'd0, 32'h00F0000F);
    run_op("slt",  3'b101, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        3'd2, 32'd1);
    run_op("sltu", 3'b010, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd1,        3'd3, 32'd0);

    // Backpressure: grant low, three ops offered, only two credits.
    @(negedge clk);
    cdb_grant = 1'b0;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 3'd1);
    #1 checkOutput("bp_ready0", issue_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 32'd2, 32'd2, 3'd2);
    #1 checkOutput("bp_ready1", issue_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 32'd3, 32'd3, 3'd5);
    #1 checkOutput("bp_ready2", issue_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_ready", issue_ready, 1'b0);
      checkOutput("bp_hold_tag", cdb_tag, 3'd1);
      checkOutput("bp_hold_data", cdb_data, 32'd2);
    end
    cdb_grant = 1'b1;
    #1 checkOutput("bp_ready_on_pop", issue_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'b0, 1'b0, 1'b0, '0, '0, '0);
    checkOutput("bp_drain1_tag", cdb_tag, 3'd2);
    checkOutput("bp_drain1_data", cdb_data, 32'd4);
    @(negedge clk);
    checkOutput("bp_drain2_req", cdb_req, 1'b1);
    checkOutput("bp_drain2_tag", cdb_tag, 3'd5);
    checkOutput("bp_drain2_data", cdb_data, 32'd6);
    @(negedge clk);
    checkOutput("bp_empty_req", cdb_req, 1'b0);
    checkOutput("bp_empty_busy", busy, 1'b0);

    // Throughput: one op per cycle with grant held, tags 0..7 back to back.
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i < 8) applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, i, 32'd100, i[2:0]);
      else       applyStimulus(1'b0, 3'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      if (i < 8) checkOutput("tp_ready", issue_ready, 1'b1);
      if (i >= 2 && i <= 9) begin
        checkOutput("tp_req", cdb_req, 1'b1);
        checkOutput("tp_tag", cdb_tag, i - 2);
        checkOutput("tp_data", cdb_data, i - 2 + 100);
      end else begin
        checkOutput("tp_idle_req", cdb_req, 1'b0);
      end
    end

    // Flush with two results queued and an issue attempt in the same cycle.
    @(negedge clk);
    cdb_grant = 1'b0;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 3'd1);
    @(negedge clk);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 32'd8, 32'd8, 3'd2);
    @(negedge clk);
    applyStimulus(1'b0, 3'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("fl_queued_tag", cdb_tag, 3'd1);
    flush = 1'b1;
    cdb_grant = 1'b1;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 32'd7, 32'd7, 3'd3);
    #1 checkOutput("fl_ready", issue_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, 3'b0, 1'b0, 1'b0, '0, '0, '0);
    #1 checkOutput("fl_req", cdb_req, 1'b0);
    checkOutput("fl_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("fl_no_late_req", cdb_req, 1'b0);

    // Asynchronous reset in the middle of a clock phase with a result pending.
    cdb_grant = 1'b0;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 32'd4, 32'd4, 3'd6);
    @(negedge clk);
    applyStimulus(1'b0, 3'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("ar_pending_req", cdb_req, 1'b1);
    #2 rst = 1'b0;
    #1 checkOutput("ar_req", cdb_req, 1'b0);
    checkOutput("ar_busy", busy, 1'b0);
    checkOutput("ar_data", cdb_data, 32'd0);
    checkOutput("ar_tag", cdb_tag, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("ar_after_req", cdb_req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
